// File: rtl/contador_pkg.sv
// Shared types and constants for the loadable down-counter.
package contador_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // A prescaler register never shrinks below one bit, even when DIV is 1.
  function automatic int presc_w(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/bcd_dig_dec.sv
// One packed-BCD digit of a decimal down-counter: subtracts the incoming borrow.
module bcd_dig_dec
  import contador_pkg::*;
(
  input  logic [3:0] dig,
  input  logic       borrow_in,
  output logic [3:0] dig_out,
  output logic       borrow_out
);

  always_comb begin
    dig_out    = dig;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (dig == 4'd0) begin
        dig_out    = BCD_MAX;
        borrow_out = 1'b1;
      end else begin
        dig_out = dig - 4'd1;
      end
    end
  end

endmodule

// File: rtl/contador_dec_carga.sv
// Loadable down-counter with prescaler, terminal-count pulse and optional auto-reload.
// Define CONTADOR_DEC_BCD_EN for packed-BCD counting with digit clamping at load.
module contador_dec_carga
  import contador_pkg::*;
#(
  parameter int N   = 8,
  parameter int DIV = 1
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         i_Load,
  input  logic [N-1:0] i_Val,
  input  logic         i_Dec,
  input  logic         i_Auto,
  output logic [N-1:0] o_Cta,
  output logic         o_Cero,
  output logic         o_Fin,
  output logic         o_Busy
);

  localparam int             PW         = presc_w(DIV);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(DIV - 1);

  state_t        state, state_nxt;
  logic [N-1:0]  cta, cta_nxt;
  logic [N-1:0]  reload, reload_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic          fin, fin_nxt;
  logic [N-1:0]  dec_val;
  logic [N-1:0]  load_val;

`ifdef CONTADOR_DEC_BCD_EN
  function automatic logic [N-1:0] clamp_bcd(input logic [N-1:0] v);
    logic [N-1:0] r;
    r = v;
    for (int i = 0; i < N / 4; i++) begin
      if (v[4*i +: 4] > BCD_MAX) r[4*i +: 4] = BCD_MAX;
    end
    return r;
  endfunction

  // Borrow ripples from the least significant digit; the top borrow cannot
  // assert because a decrement only fires while the count is above one.
  logic [N/4:0] borrow;
  assign borrow[0] = 1'b1;

  for (genvar g = 0; g < N / 4; g++) begin : g_dig
    bcd_dig_dec u_dig (
      .dig        (cta[4*g +: 4]),
      .borrow_in  (borrow[g]),
      .dig_out    (dec_val[4*g +: 4]),
      .borrow_out (borrow[g+1])
    );
  end

  assign load_val = clamp_bcd(i_Val);
`else
  assign dec_val  = cta - N'(1);
  assign load_val = i_Val;
`endif

  always_comb begin
    state_nxt  = state;
    cta_nxt    = cta;
    reload_nxt = reload;
    presc_nxt  = presc;
    fin_nxt    = 1'b0;
    if (i_Load) begin
      cta_nxt    = load_val;
      reload_nxt = load_val;
      presc_nxt  = '0;
      state_nxt  = (load_val != '0) ? COUNT : IDLE;
    end else if (state == COUNT && i_Dec) begin
      if (presc == PRESC_LAST) begin
        presc_nxt = '0;
        if (cta == N'(1)) begin
          fin_nxt = 1'b1;
          if (i_Auto) begin
            cta_nxt = reload;
          end else begin
            cta_nxt   = '0;
            state_nxt = DONE;
          end
        end else begin
          cta_nxt = dec_val;
        end
      end else begin
        presc_nxt = presc + 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state  <= IDLE;
      cta    <= '0;
      reload <= '0;
      presc  <= '0;
      fin    <= 1'b0;
    end else begin
      state  <= state_nxt;
      cta    <= cta_nxt;
      reload <= reload_nxt;
      presc  <= presc_nxt;
      fin    <= fin_nxt;
    end
  end

  assign o_Cta  = cta;
  assign o_Cero = (cta == '0);
  assign o_Fin  = fin;
  assign o_Busy = (state == COUNT);

endmodule

// File: tb/tb_contador_dec_carga.sv
// Directed scoreboard bench for contador_dec_carga: DIV=1 and DIV=3 instances share stimulus.
module tb_contador_dec_carga;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load = 1'b0;
  logic [N-1:0] val = '0;
  logic         dec = 1'b0;
  logic         auto_rl = 1'b0;

  logic [N-1:0] cta1, cta3;
  logic         cero1, fin1, busy1, cero3, fin3, busy3;

  typedef struct {
    string        tag;
    bit           sel3;
    logic [N-1:0] cta;
    logic         cero;
    logic         fin;
    logic         busy;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  contador_dec_carga #(.N(N), .DIV(1)) dut1 (
    .i_Clk (clk), .i_Rst (rst), .i_Load (load), .i_Val (val),
    .i_Dec (dec), .i_Auto (auto_rl),
    .o_Cta (cta1), .o_Cero (cero1), .o_Fin (fin1), .o_Busy (busy1)
  );

  contador_dec_carga #(.N(N), .DIV(3)) dut3 (
    .i_Clk (clk), .i_Rst (rst), .i_Load (load), .i_Val (val),
    .i_Dec (dec), .i_Auto (auto_rl),
    .o_Cta (cta3), .o_Cero (cero3), .o_Fin (fin3), .o_Busy (busy3)
  );

  task automatic check_out();
    exp_t e;
    logic [N+2:0] obs, req;
    e = sb.pop_front();
    if (e.sel3) obs = {cta3, cero3, fin3, busy3};
    else        obs = {cta1, cero1, fin1, busy1};
    req = {e.cta, e.cero, e.fin, e.busy};
    n_checks++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s: observed cta=%h cero=%b fin=%b busy=%b, expected cta=%h cero=%b fin=%b busy=%b",
             e.tag, obs[N+2:3], obs[2], obs[1], obs[0], e.cta, e.cero, e.fin, e.busy);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then check.
  task automatic step(input string tag, input bit sel3,
                      input logic r, input logic ld, input logic [N-1:0] v,
                      input logic d, input logic a,
                      input logic [N-1:0] e_cta, input logic e_cero,
                      input logic e_fin, input logic e_busy);
    exp_t e;
    rst = r; load = ld; val = v; dec = d; auto_rl = a;
    e.tag = tag; e.sel3 = sel3; e.cta = e_cta;
    e.cero = e_cero; e.fin = e_fin; e.busy = e_busy;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    check_out();
  endtask

  initial begin
    @(negedge clk);

    // Reset, then load 3 and count down to DONE.
    step("rst_a",      0, 1, 0, 8'd0, 0, 0, 8'd0, 1, 0, 0);
    step("rst_b",      0, 1, 0, 8'd0, 0, 0, 8'd0, 1, 0, 0);
    step("load3",      0, 0, 1, 8'd3, 1, 0, 8'd3, 0, 0, 1);
    step("dn_2",       0, 0, 0, 8'd0, 1, 0, 8'd2, 0, 0, 1);
    step("dn_1",       0, 0, 0, 8'd0, 1, 0, 8'd1, 0, 0, 1);
    step("term_0",     0, 0, 0, 8'd0, 1, 0, 8'd0, 1, 1, 0);
    step("done_hold",  0, 0, 0, 8'd0, 1, 0, 8'd0, 1, 0, 0);
    step("done_hold2", 0, 0, 0, 8'd0, 1, 0, 8'd0, 1, 0, 0);

    // Auto-reload: 2,1,2,1,2 with a pulse on each reload.
    step("ar_load2",   0, 0, 1, 8'd2, 1, 1, 8'd2, 0, 0, 1);
    step("ar_1",       0, 0, 0, 8'd0, 1, 1, 8'd1, 0, 0, 1);
    step("ar_rl_a",    0, 0, 0, 8'd0, 1, 1, 8'd2, 0, 1, 1);
    step("ar_1b",      0, 0, 0, 8'd0, 1, 1, 8'd1, 0, 0, 1);
    step("ar_rl_b",    0, 0, 0, 8'd0, 1, 1, 8'd2, 0, 1, 1);

    // Load wins over a simultaneous decrement; a zero load idles.
    step("coll_5",     0, 0, 1, 8'd5, 1, 0, 8'd5, 0, 0, 1);
    step("dn_4",       0, 0, 0, 8'd0, 1, 0, 8'd4, 0, 0, 1);
    step("load0",      0, 0, 1, 8'd0, 1, 0, 8'd0, 1, 0, 0);
    step("idle_hold",  0, 0, 0, 8'd0, 1, 0, 8'd0, 1, 0, 0);

    // Prescaler DIV=3: changes only on every third accepted strobe.
    step("p_rst",      1, 1, 0, 8'd0, 0, 0, 8'd0, 1, 0, 0);
    step("p_load2",    1, 0, 1, 8'd2, 0, 0, 8'd2, 0, 0, 1);
    step("p_s1",       1, 0, 0, 8'd0, 1, 0, 8'd2, 0, 0, 1);
    step("p_gap",      1, 0, 0, 8'd0, 0, 0, 8'd2, 0, 0, 1);
    step("p_s2",       1, 0, 0, 8'd0, 1, 0, 8'd2, 0, 0, 1);
    step("p_s3",       1, 0, 0, 8'd0, 1, 0, 8'd1, 0, 0, 1);
    step("p_s4",       1, 0, 0, 8'd0, 1, 0, 8'd1, 0, 0, 1);
    step("p_s5",       1, 0, 0, 8'd0, 1, 0, 8'd1, 0, 0, 1);
    step("p_s6",       1, 0, 0, 8'd0, 1, 0, 8'd0, 1, 1, 0);
    step("p_after",    1, 0, 0, 8'd0, 1, 0, 8'd0, 1, 0, 0);

    // Mid-count reset after strobe 4, then a fresh count starts from a clear prescaler.
    step("m_load2",    1, 0, 1, 8'd2, 0, 0, 8'd2, 0, 0, 1);
    step("m_s1",       1, 0, 0, 8'd0, 1, 0, 8'd2, 0, 0, 1);
    step("m_s2",       1, 0, 0, 8'd0, 1, 0, 8'd2, 0, 0, 1);
    step("m_s3",       1, 0, 0, 8'd0, 1, 0, 8'd1, 0, 0, 1);
    step("m_s4",       1, 0, 0, 8'd0, 1, 0, 8'd1, 0, 0, 1);
    step("m_rst",      1, 1, 0, 8'd0, 1, 0, 8'd0, 1, 0, 0);
    step("m_rst_dec",  1, 0, 0, 8'd0, 1, 0, 8'd0, 1, 0, 0);
    step("m_reload",   1, 0, 1, 8'd2, 0, 0, 8'd2, 0, 0, 1);
    step("m_r1",       1, 0, 0, 8'd0, 1, 0, 8'd2, 0, 0, 1);
    step("m_r2",       1, 0, 0, 8'd0, 1, 0, 8'd2, 0, 0, 1);
    step("m_r3",       1, 0, 0, 8'd0, 1, 0, 8'd1, 0, 0, 1);

`ifdef CONTADOR_DEC_BCD_EN
    // Decimal borrow and digit clamping.
    step("b_load10",   0, 0, 1, 8'h10, 0, 0, 8'h10, 0, 0, 1);
    step("b_dn09",     0, 0, 0, 8'h00, 1, 0, 8'h09, 0, 0, 1);
    step("b_loadA5",   0, 0, 1, 8'hA5, 0, 0, 8'h95, 0, 0, 1);
    step("b_dn94",     0, 0, 0, 8'h00, 1, 0, 8'h94, 0, 0, 1);
    step("b_load1A",   0, 0, 1, 8'h1A, 0, 0, 8'h19, 0, 0, 1);
`else
    // Binary decrement across a nibble boundary.
    step("x_load10",   0, 0, 1, 8'h10, 0, 0, 8'h10, 0, 0, 1);
    step("x_dn0f",     0, 0, 0, 8'h00, 1, 0, 8'h0F, 0, 0, 1);
    step("x_loadA5",   0, 0, 1, 8'hA5, 0, 0, 8'hA5, 0, 0, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against a stalled clock or bench.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
